piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready

---
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// piso_serializer : valid/ready parallel-in, serial-out transmitter with
//                   start/done framing strobes. Optional macro: PISO_PARITY_EN
// Rev 1.0
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int              CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PREV_CNT = CNT_W'(FRAME_LEN - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sout_q, sout_d;
  logic                   sout_valid_q, sout_valid_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_done_q, frame_done_d;

  logic [WIDTH-1:0]       w_d_ordered;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_last_bit;
  logic                   w_accept;

  // Frame vector is laid out in transmit order: bit FRAME_LEN-1 goes first.
  always_comb begin
    w_d_ordered = d;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_d_ordered[i] = d[WIDTH-1-i];
      end
    end
  end

`ifdef PISO_PARITY_EN
  assign w_frame = {w_d_ordered, ^d};
`else
  assign w_frame = w_d_ordered;
`endif

  assign w_last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign d_ready    = (state_q == IDLE) || w_last_bit;
  assign w_accept   = d_valid && d_ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    if (w_accept) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      sout_d        = w_frame[FRAME_LEN-1];
      shreg_d       = w_frame << 1;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (state_q == SHIFT) begin
      if (w_last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        cnt_d        = cnt_q + CNT_W'(1);
        sout_d       = shreg_q[FRAME_LEN-1];
        shreg_d      = shreg_q << 1;
        sout_valid_d = 1'b1;
        frame_done_d = (cnt_q == PREV_CNT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = sout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// tb_piso_serializer : randomized bench against a queue-based frame model,
//                      MSB-first and LSB-first instances driven in parallel.
// Rev 1.0
// ============================================================================
module tb_piso_serializer;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] d = '0;
  logic         d_valid = 1'b0;

  logic m_ready, m_sout, m_valid, m_start, m_done, m_busy;
  logic l_ready, l_sout, l_valid, l_start, l_done, l_busy;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(m_ready),
    .sout(m_sout), .sout_valid(m_valid), .frame_start(m_start),
    .frame_done(m_done), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(l_ready),
    .sout(l_sout), .sout_valid(l_valid), .frame_start(l_start),
    .frame_done(l_done), .busy(l_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each accepted word becomes a list of serial bit slots; one slot
  // is presented per clock, idle when the list is empty.
  typedef struct packed {
    logic v;
    logic b;
    logic s;
    logic e;
  } slot_t;

  slot_t q_m[$];
  slot_t q_l[$];
  slot_t cur_m = '0;
  slot_t cur_l = '0;

  function automatic logic model_ready();
    return !cur_m.v || cur_m.e;
  endfunction

  task automatic model_accept(input logic [W-1:0] w);
    slot_t sm, sl;
    for (int k = 0; k < FL; k++) begin
      sm.v = 1'b1; sl.v = 1'b1;
      sm.s = (k == 0); sl.s = (k == 0);
      sm.e = (k == FL - 1); sl.e = (k == FL - 1);
      sm.b = (k < W) ? w[W-1-k] : ^w;
      sl.b = (k < W) ? w[k] : ^w;
      q_m.push_back(sm);
      q_l.push_back(sl);
    end
  endtask

  task automatic model_edge();
    if (d_valid && model_ready()) model_accept(d);
    cur_m = (q_m.size() > 0) ? q_m.pop_front() : '0;
    cur_l = (q_l.size() > 0) ? q_l.pop_front() : '0;
  endtask

  task automatic model_reset();
    q_m.delete();
    q_l.delete();
    cur_m = '0;
    cur_l = '0;
  endtask

  task automatic check_ready();
    check("msb_d_ready", m_ready, model_ready());
    check("lsb_d_ready", l_ready, model_ready());
  endtask

  task automatic check_outputs();
    check("msb_sout",        m_sout,  cur_m.b);
    check("msb_sout_valid",  m_valid, cur_m.v);
    check("msb_frame_start", m_start, cur_m.s);
    check("msb_frame_done",  m_done,  cur_m.e);
    check("msb_busy",        m_busy,  cur_m.v);
    check("lsb_sout",        l_sout,  cur_l.b);
    check("lsb_sout_valid",  l_valid, cur_l.v);
    check("lsb_frame_start", l_start, cur_l.s);
    check("lsb_frame_done",  l_done,  cur_l.e);
    check("lsb_busy",        l_busy,  cur_l.v);
    check_ready();
  endtask

  // Drive inputs mid-cycle, then advance one edge and compare.
  task automatic cycle(input logic [W-1:0] nd, input logic nv);
    d       = nd;
    d_valid = nv;
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset state, with d_valid asserted to show nothing is accepted.
    d = 4'b1111; d_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Single frame 1010.
    cycle(4'b1010, 1'b1);
    repeat (FL + 1) cycle(4'b0000, 1'b0);

    // Back-to-back frames, second word held until taken.
    cycle(4'b1100, 1'b1);
    repeat (FL) cycle(4'b1111, 1'b1);
    repeat (FL + 1) cycle(4'b0000, 1'b0);

    // Input changes mid-frame must not disturb the frame in flight.
    cycle(4'b0001, 1'b1);
    repeat (FL - 1) cycle(4'b1111, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0);

    // Parity sample words (plain frames when parity is off).
    cycle(4'b1011, 1'b1);
    repeat (FL - 1) cycle(4'b1010, 1'b1);
    repeat (FL + 1) cycle(4'b0000, 1'b0);

    // Reset asserted mid-frame: immediate abort.
    cycle(4'b1010, 1'b1);
    cycle(4'b0000, 1'b0);
    #1 rst = 1'b0;
    d = 4'b1111; d_valid = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    repeat (2) cycle(4'b0000, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(W'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (FL + 1) cycle(4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
